// File: rtl/gcd_engine_if.sv
// Operand and result handshake bundle for gcd_engine: the producer/consumer
// side uses the master modport, the engine uses the slave modport.
interface gcd_engine_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic [WIDTH-1:0] out_iters;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_gcd, out_iters, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_gcd, out_iters, busy
    );
endinterface

// File: rtl/gcd_engine.sv
// Iterative subtractive GCD engine: one subtraction per clock, valid/ready on
// both sides, zero operands resolve immediately, subtraction count reported.
module gcd_engine #(
    parameter int unsigned WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    gcd_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] iter_r;
    logic [WIDTH-1:0] gcd_r;
    logic [WIDTH-1:0] iters_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            iter_r      <= '0;
            gcd_r       <= '0;
            iters_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.in_a;
                        b_r        <= bus.in_b;
                        iter_r     <= '0;
                        state      <= CALC;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                CALC: begin
                    // Termination checks take priority over subtraction; a zero
                    // operand makes the other one the result.
                    if (a_r == '0 || b_r == '0 || a_r == b_r) begin
                        gcd_r       <= (a_r == '0) ? b_r : a_r;
                        iters_r     <= iter_r;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else if (a_r > b_r) begin
                        a_r    <= a_r - b_r;
                        iter_r <= iter_r + 1'b1;
                    end else begin
                        b_r    <= b_r - a_r;
                        iter_r <= iter_r + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_gcd   = gcd_r;
    assign bus.out_iters = iters_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_gcd_engine.sv
// Randomised scoreboard bench for gcd_engine at WIDTH=8 and WIDTH=16 against a
// Euclidean-division reference of gcd and subtraction count.
module tb_gcd_engine;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   rnd_bp = 0;

    typedef struct {
        int unsigned g;
        int unsigned it;
        int          acc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    bit   prev8 = 0;
    bit   prev16 = 0;

    gcd_engine_if #(.WIDTH(8))  bus8 ();
    gcd_engine_if #(.WIDTH(16)) bus16 ();

    gcd_engine #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    gcd_engine #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Subtractive GCD counted via Euclid: each division step contributes its
    // quotient, except the exact-division step, which stops at equality.
    function automatic void ref_gcd(input longint unsigned a0, input longint unsigned b0,
                                    output int unsigned g, output int unsigned it);
        longint unsigned a, b, t, q, r;
        bit done;
        a = a0; b = b0; it = 0; g = 0; done = 0;
        if (a == 0 || b == 0) begin
            g = int'(a + b);
            done = 1;
        end
        while (!done) begin
            if (a < b) begin t = a; a = b; b = t; end
            q = a / b;
            r = a % b;
            if (r == 0) begin
                it += int'(q - 1);
                g = int'(b);
                done = 1;
            end else begin
                it += int'(q);
                a = r;
            end
        end
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) prev8 = 0;
        else begin
            if (prev8 && bus8.out_ready) begin
                chk("hs8_out_valid_low", bus8.out_valid, 0);
                chk("hs8_in_ready_back", bus8.in_ready, 1);
                if (q8.size() != 0) void'(q8.pop_front());
            end else if (bus8.out_valid && !prev8) begin
                if (q8.size() == 0) chk("spurious8", q8.size(), 1);
                else begin
                    e = q8[0];
                    chk("lat8", cyc - e.acc, e.it + 1);
                    chk("gcd8", bus8.out_gcd, e.g);
                    chk("iters8", bus8.out_iters, e.it);
                end
            end else if (bus8.out_valid && q8.size() != 0) begin
                chk("hold_gcd8", bus8.out_gcd, q8[0].g);
                chk("hold_iters8", bus8.out_iters, q8[0].it);
            end
            prev8 = bus8.out_valid;
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) prev16 = 0;
        else begin
            if (prev16 && bus16.out_ready) begin
                chk("hs16_out_valid_low", bus16.out_valid, 0);
                chk("hs16_in_ready_back", bus16.in_ready, 1);
                if (q16.size() != 0) void'(q16.pop_front());
            end else if (bus16.out_valid && !prev16) begin
                if (q16.size() == 0) chk("spurious16", q16.size(), 1);
                else begin
                    e = q16[0];
                    chk("lat16", cyc - e.acc, e.it + 1);
                    chk("gcd16", bus16.out_gcd, e.g);
                    chk("iters16", bus16.out_iters, e.it);
                end
            end
            prev16 = bus16.out_valid;
        end
    end

    always @(negedge clk) begin
        if (rnd_bp) begin
            bus8.out_ready  = 1'($urandom_range(0, 1));
            bus16.out_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic bit rdy(input bit wide);
        return wide ? bus16.in_ready : bus8.in_ready;
    endfunction

    task automatic send(input bit wide, input int unsigned a, input int unsigned b);
        exp_t e;
        int n;
        ref_gcd(a, b, e.g, e.it);
        n = 0;
        @(negedge clk);
        while (!rdy(wide) && n < 80000) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(wide)) begin
            chk("accept_timeout", n, 0);
            return;
        end
        e.acc = cyc + 1;
        if (wide) begin
            bus16.in_a = a[15:0]; bus16.in_b = b[15:0]; bus16.in_valid = 1'b1;
            q16.push_back(e);
        end else begin
            bus8.in_a = a[7:0]; bus8.in_b = b[7:0]; bus8.in_valid = 1'b1;
            q8.push_back(e);
        end
        @(negedge clk);
        if (wide) begin
            bus16.in_valid = 1'b0;
            bus16.in_a = 16'($urandom);
            chk("busy16_after_accept", bus16.busy, 1);
            chk("in_ready16_after_accept", bus16.in_ready, 0);
        end else begin
            bus8.in_valid = 1'b0;
            bus8.in_a = 8'($urandom);
            chk("busy8_after_accept", bus8.busy, 1);
            chk("in_ready8_after_accept", bus8.in_ready, 0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 80000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q8.size() + q16.size(), 0);
        q8.delete();
        q16.delete();
    endtask

    task automatic chk_reset_state();
        chk("rst8_in_ready", bus8.in_ready, 1);
        chk("rst8_out_valid", bus8.out_valid, 0);
        chk("rst8_busy", bus8.busy, 0);
        chk("rst8_out_gcd", bus8.out_gcd, 0);
        chk("rst8_out_iters", bus8.out_iters, 0);
        chk("rst16_in_ready", bus16.in_ready, 1);
        chk("rst16_out_valid", bus16.out_valid, 0);
        chk("rst16_out_gcd", bus16.out_gcd, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus8.in_valid = 1'b0;  bus8.in_a = '0;  bus8.in_b = '0;  bus8.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst = 1'b0;

        send(0, 12, 8);
        send(0, 0, 0);
        send(0, 0, 9);
        send(0, 9, 0);
        send(0, 7, 7);
        send(0, 255, 1);
        send(0, 13, 8);
        drain();

        // Back-pressure: result must stay put while stray operands are offered.
        bus8.out_ready = 1'b0;
        send(0, 18, 12);
        n = 0;
        while (!bus8.out_valid && n < 100) begin @(negedge clk); n++; end
        chk("bp_valid_seen", bus8.out_valid, 1);
        repeat (10) begin
            bus8.in_valid = 1'b1;
            bus8.in_a = 8'($urandom);
            bus8.in_b = 8'($urandom);
            @(negedge clk);
            chk("bp_in_ready_low", bus8.in_ready, 0);
            chk("bp_out_valid_high", bus8.out_valid, 1);
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        chk("bp_single_handshake", bus8.out_valid, 0);

        // Reset in the middle of a long computation discards it.
        send(0, 200, 3);
        repeat (5) @(negedge clk);
        chk("midop_busy", bus8.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q8.delete();
        chk_reset_state();
        send(0, 36, 24);
        drain();

        send(1, 65535, 65534);
        drain();

        rnd_bp = 1;
        for (int i = 0; i < 30; i++) send(0, $urandom_range(0, 255), $urandom_range(0, 255));
        for (int i = 0; i < 10; i++) send(1, $urandom_range(0, 2047), $urandom_range(0, 2047));
        drain();
        rnd_bp = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
